// File: rtl/arith_seq_unit.sv
// Sequential add/sub/mul/div engine behind a valid/ready command port.
// Define ARITH_SEQ_REM_EN to add the remainder output port `rem`.
module arith_seq_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] outau,
    output logic             err,
`ifdef ARITH_SEQ_REM_EN
    output logic [WIDTH-1:0] rem,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_MUL = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opa;   // multiplicand (MUL) / dividend shifting into quotient (DIV)
    logic [WIDTH-1:0] opb;   // multiplier (MUL) / divisor (DIV)
    logic [WIDTH-1:0] acc;   // product (MUL) / partial remainder (DIV)

    logic             last;
    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   r_sub;
    logic             ge;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;

    // Partial remainder stays below the divisor, so bit WIDTH of r_sub is the borrow.
    always_comb begin
        last    = (cnt == CNT_W'(WIDTH - 1));
        mul_sum = acc + (opb[0] ? opa : '0);
        r_sh    = {acc, opa[WIDTH-1]};
        r_sub   = r_sh - {1'b0, opb};
        ge      = ~r_sub[WIDTH];
        q_next  = {opa[WIDTH-2:0], ge};
        r_next  = ge ? r_sub[WIDTH-1:0] : r_sh[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            opa       <= '0;
            opb       <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            outau     <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
`ifdef ARITH_SEQ_REM_EN
            rem       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        opa      <= a;
                        opb      <= b;
                        acc      <= '0;
                        err      <= 1'b0;
`ifdef ARITH_SEQ_REM_EN
                        rem      <= '0;
`endif
                        case (opcode)
                            OP_ADD: begin
                                outau     <= a + b;
                                state     <= DONE;
                                out_valid <= 1'b1;
                            end
                            OP_SUB: begin
                                outau     <= a - b;
                                state     <= DONE;
                                out_valid <= 1'b1;
                            end
                            OP_MUL: state <= MUL;
                            OP_DIV: begin
                                if (b == '0) begin
                                    outau     <= '1;
                                    err       <= 1'b1;
`ifdef ARITH_SEQ_REM_EN
                                    rem       <= a;
`endif
                                    state     <= DONE;
                                    out_valid <= 1'b1;
                                end else begin
                                    state <= DIV;
                                end
                            end
                            default: begin
                                outau     <= '0;
                                err       <= 1'b1;
                                state     <= DONE;
                                out_valid <= 1'b1;
                            end
                        endcase
                    end
                end
                MUL: begin
                    acc <= mul_sum;
                    opa <= opa << 1;
                    opb <= opb >> 1;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        outau     <= mul_sum;
                        err       <= 1'b0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DIV: begin
                    acc <= r_next;
                    opa <= q_next;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        outau     <= q_next;
                        err       <= 1'b0;
`ifdef ARITH_SEQ_REM_EN
                        rem       <= r_next;
`endif
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arith_seq_unit.sv
// Randomized + directed bench for arith_seq_unit against a plain-arithmetic model.
module tb_arith_seq_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   opcode = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] outau;
    logic         err;
    logic         busy;
`ifdef ARITH_SEQ_REM_EN
    logic [W-1:0] rem;
`endif

    always #5 clk = ~clk;

    arith_seq_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
        .outau(outau), .err(err),
`ifdef ARITH_SEQ_REM_EN
        .rem(rem),
`endif
        .busy(busy)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         er;
        logic [W-1:0] rm;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   seen_first = 0;
    bit   rand_rdy = 0;
    bit   mon_fire;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] op);
        exp_t e;
        e.res = '0; e.er = 1'b0; e.rm = '0; e.lat = 1; e.acc_cyc = 0;
        case (op)
            3'd0: e.res = x + y;
            3'd1: begin e.res = x * y; e.lat = W + 1; end
            3'd2: e.res = x - y;
            3'd3: begin
                if (y == 0) begin e.res = '1; e.er = 1'b1; e.rm = x; end
                else begin e.res = x / y; e.rm = x % y; e.lat = W + 1; end
            end
            default: e.er = 1'b1;
        endcase
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: every cycle checks handshake outputs and, while valid, the result.
    always @(posedge clk) begin
        mon_fire = out_valid && out_ready && rst_n;
        #1;
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_outau", outau, 0);
            chk("rst_err", err, 0);
        end else begin
            if (mon_fire && q.size() > 0) begin
                void'(q.pop_front());
                seen_first = 0;
            end
            chk("in_ready", in_ready, (q.size() == 0));
            chk("busy", busy, (q.size() != 0));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 0);
                end else begin
                    if (!seen_first) begin
                        chk("latency", cyc - q[0].acc_cyc + 1, q[0].lat);
                        seen_first = 1;
                    end
                    chk("outau", outau, q[0].res);
                    chk("err", err, q[0].er);
`ifdef ARITH_SEQ_REM_EN
                    chk("rem", rem, q[0].rm);
`endif
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] op);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (!in_ready) chk("send_timeout", 0, 1);
        a = x; b = y; opcode = op; in_valid = 1'b1;
        e = model(x, y, op);
        e.acc_cyc = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; opcode = 3'($urandom);
    endtask

    // Waits for out_valid; k counts cycles from the accept edge.
    task automatic wait_valid(output int k);
        k = 1;
        while (!out_valid && k < 100) begin @(negedge clk); k++; end
        if (!out_valid) chk("valid_timeout", 0, 1);
    endtask

    task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] op,
                            input logic [W-1:0] xres, input logic xerr, input logic [W-1:0] xrem,
                            input int xlat);
        int k;
        send(x, y, op);
        wait_valid(k);
        chk("dir_latency", k, xlat);
        chk("dir_outau", outau, xres);
        chk("dir_err", err, xerr);
`ifdef ARITH_SEQ_REM_EN
        chk("dir_rem", rem, xrem);
`else
        if (xrem != xrem) chk("dir_rem_unused", 0, 1);
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int k;
        logic [W-1:0] hold_res;
        logic         hold_err;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        directed(10, 5, 3'b000, 15, 0, 0, 1);
        directed(10, 5, 3'b001, 50, 0, 0, 33);
        directed(32'hFFFF_FFFF, 2, 3'b001, 32'hFFFF_FFFE, 0, 0, 33);
        directed(10, 5, 3'b010, 5, 0, 0, 1);
        directed(5, 10, 3'b010, 32'hFFFF_FFFB, 0, 0, 1);
        directed(10, 5, 3'b011, 2, 0, 0, 33);
        directed(7, 0, 3'b011, 32'hFFFF_FFFF, 1, 7, 1);
        directed(100, 7, 3'b011, 14, 0, 2, 33);

        // Backpressure: result held, extra command ignored.
        send(1234, 4321, 3'b000);
        wait_valid(k);
        hold_res = outau;
        hold_err = err;
        a = 3; b = 4; opcode = 3'b001; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_outau", outau, hold_res);
            chk("bp_err", err, hold_err);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle_ready", in_ready, 1);
        directed(77, 88, 3'b101, 0, 1, 0, 1);

        // Reset in the middle of a divide.
        send(1000, 3, 3'b011);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        seen_first = 0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_outau", outau, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        directed(9, 3, 3'b011, 3, 0, 0, 33);

        // Random phase with random consumer backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] x, y;
            logic [2:0]   op;
            op = 3'($urandom_range(0, 7));
            x  = $urandom;
            case ($urandom_range(0, 3))
                0: y = '0;
                1: y = $urandom_range(1, 20);
                default: y = $urandom;
            endcase
            send(x, y, op);
        end
        k = 0;
        while (q.size() != 0 && k < 300) begin @(negedge clk); k++; end
        chk("drain", q.size(), 0);
        rand_rdy = 1'b0;
        out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arith_seq_unit.md
Name: arith_seq_unit

Overview:
- Sequential request/response arithmetic engine: the responder that executes the add/mul/sub/div opcodes that arith-style commands carry.
- Accepts one command (a, b, opcode) per valid/ready handshake.
- Add and sub complete in one cycle; mul and div are iterative, one bit per cycle.
- Sits between the CPU control path and the register writeback, so long operations no longer need a combinational multiplier or divider.

Parameters:
- WIDTH, 32, operand and result width in bits (min 4).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  command valid.
- in_ready  out  1  engine can accept a command.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- opcode  in  3  000 add, 001 mul, 010 sub, 011 div, 100-111 illegal.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- outau  out  WIDTH  result.
- err  out  1  qualifies outau; set for divide-by-zero or illegal opcode.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0, outau=0, err=0, busy=0; counter and internal accumulators cleared.
- States: IDLE, MUL, DIV, DONE. in_ready=1 only in IDLE.
- Accept: in_valid & in_ready at a rising edge. Operands and opcode are latched; later input changes have no effect.
- IDLE, add: outau<=a+b, truncated to WIDTH (carry dropped); go to DONE.
- IDLE, sub: outau<=a-b modulo 2^WIDTH (e.g. 5-10 = 0xFFFFFFFB); go to DONE.
- IDLE, illegal opcode: outau<=0, err<=1; go to DONE.
- IDLE, div with b==0: outau<={WIDTH{1'b1}}, err<=1; go to DONE directly, no iterations.
- IDLE, mul: go to MUL, counter=0.
- IDLE, div with b!=0: go to DIV, counter=0.
- MUL: shift-add, one multiplier bit per cycle for WIDTH cycles. outau is the low WIDTH bits of the product (overflow discarded, err=0). After iteration WIDTH-1, go to DONE.
- DIV: restoring shift-subtract, one quotient bit per cycle for WIDTH cycles. outau=quotient, err=0. After iteration WIDTH-1, go to DONE.
- Latency, accept edge to first cycle out_valid=1:
  - add, sub, illegal, div-by-0: 1 cycle.
  - mul, div: WIDTH+1 cycles (33 at WIDTH=32).
- DONE: out_valid=1. outau and err stay stable until out_valid & out_ready, then go to IDLE and drop out_valid.
- No new command is accepted in the same cycle a result is consumed; minimum issue interval is 2 cycles.
- outau holds its last value in IDLE. It is meaningful only while out_valid=1.
- in_valid is ignored outside IDLE; commands are never queued.
- Reset asserted mid-MUL/DIV aborts the operation immediately. No result is produced after reset releases.
- out_ready high while out_valid=0 has no effect.

Optional Feature:
- Macro: ARITH_SEQ_REM_EN.
- Defined: adds output port rem (WIDTH bits).
  - div: rem = remainder; div-by-0: rem = a.
  - All other opcodes: rem = 0.
  - rem is valid and stable under the same out_valid/out_ready rules as outau.
  - Reset value 0.
- Not defined: port rem is absent; remainder logic is not synthesized. All other behaviour is identical.

Test Plan:
- a=10, b=5, opcode=000 -> out_valid one cycle after accept; outau=15, err=0; in_ready=0 until the result is consumed.
- a=10, b=5, opcode=001 -> out_valid exactly 33 cycles after accept; outau=50. Also a=0xFFFFFFFF, b=2 -> outau=0xFFFFFFFE.
- opcode=010: a=10, b=5 -> outau=5; a=5, b=10 -> outau=0xFFFFFFFB, err=0.
- opcode=011: a=10, b=5 -> outau=2 after 33 cycles (rem=0 with macro); a=7, b=0 -> outau=0xFFFFFFFF, err=1 after 1 cycle (rem=7 with macro).
- Backpressure: out_ready=0 for 5 cycles in DONE -> outau/err stable, out_valid held, a second in_valid ignored. Then out_ready=1 -> IDLE next cycle; opcode=101 -> outau=0, err=1.
- Reset mid-div (cycle 10 of 32): all outputs return to reset values at once. No out_valid after release; next command a=9, b=3, opcode=011 -> outau=3.
